// File: rtl/bludger_scheduler_pkg.sv
// Shared types and sizing helpers for the bludger scheduler.
package bludger_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HIT      = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  localparam int unsigned N_PLAYERS_DEFAULT = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to index/count up to v-1; never less than one bit.
  function automatic int unsigned width_of(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after the last grant, wrapping.
module rr_arbiter
  import bludger_scheduler_pkg::*;
#(
  parameter int unsigned N  = N_PLAYERS_DEFAULT,
  parameter int unsigned IW = width_of(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant_c,
  output logic [IW-1:0] o_idx_c,
  output logic          o_valid_c
);

  int unsigned w_cand;

  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    w_cand    = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = (32'(i_last) + k) % N;
      if (!o_valid_c && i_req[IW'(w_cand)]) begin
        o_valid_c = 1'b1;
        o_idx_c   = IW'(w_cand);
        o_grant_c = N'(1) << w_cand;
      end
    end
  end

endmodule

// File: rtl/bludger_scheduler.sv
// Grants the single bludger to one player at a time, with hold watchdog and cooldown.
module bludger_scheduler
  import bludger_scheduler_pkg::*;
#(
  parameter int unsigned N_PLAYERS       = N_PLAYERS_DEFAULT,
  parameter int unsigned COOLDOWN_CYCLES = 100000000,
  parameter int unsigned MAX_HOLD_CYCLES = 600000000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             game_active,
  input  logic [N_PLAYERS-1:0]             hit_req,
  input  logic [N_PLAYERS-1:0]             clean_bludge,
  output logic [N_PLAYERS-1:0]             bludged,
  output logic [width_of(N_PLAYERS)-1:0]   target,
  output logic                             busy,
  output logic                             fault
);

  localparam int unsigned TW = width_of(N_PLAYERS);
  localparam int unsigned CW = width_of(max_u(COOLDOWN_CYCLES, MAX_HOLD_CYCLES));
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_CYCLES - 1);

  state_t                r_state, w_state_nxt;
  logic [N_PLAYERS-1:0]  r_bludged, w_bludged_nxt;
  logic [TW-1:0]         r_target, w_target_nxt;
  logic                  r_fault, w_fault_nxt;
  logic                  r_busy;
  logic [CW-1:0]         r_hold_cnt, w_hold_nxt;
  logic [CW-1:0]         r_cd_cnt, w_cd_nxt;

  logic [N_PLAYERS-1:0]  w_grant;
  logic [TW-1:0]         w_grant_idx;
  logic                  w_grant_vld;
  logic                  w_clean_tgt;

  rr_arbiter #(
    .N  (N_PLAYERS),
    .IW (TW)
  ) u_rr (
    .i_req     (hit_req),
    .i_last    (r_target),
    .o_grant_c (w_grant),
    .o_idx_c   (w_grant_idx),
    .o_valid_c (w_grant_vld)
  );

  assign w_clean_tgt = clean_bludge[r_target];

  // Next-state logic; abort has top priority, then clean release over watchdog.
  always_comb begin
    w_state_nxt   = r_state;
    w_bludged_nxt = r_bludged;
    w_target_nxt  = r_target;
    w_fault_nxt   = r_fault;
    w_hold_nxt    = r_hold_cnt;
    w_cd_nxt      = r_cd_cnt;
    if (!game_active) begin
      w_state_nxt   = ST_IDLE;
      w_bludged_nxt = '0;
      w_hold_nxt    = '0;
      w_cd_nxt      = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_vld) begin
            w_state_nxt   = ST_HIT;
            w_bludged_nxt = w_grant;
            w_target_nxt  = w_grant_idx;
            w_hold_nxt    = '0;
          end
        end
        ST_HIT: begin
          if (w_clean_tgt || (r_hold_cnt == HOLD_LAST)) begin
            w_state_nxt   = ST_COOLDOWN;
            w_bludged_nxt = '0;
            w_hold_nxt    = '0;
            w_cd_nxt      = COOL_LOAD;
            if (!w_clean_tgt) w_fault_nxt = 1'b1;
          end else begin
            w_hold_nxt = r_hold_cnt + CW'(1);
          end
        end
        ST_COOLDOWN: begin
          if (r_cd_cnt == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_cd_nxt = r_cd_cnt - CW'(1);
          end
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_bludged_nxt = '0;
          w_hold_nxt    = '0;
          w_cd_nxt      = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bludged  <= '0;
      r_target   <= TW'(N_PLAYERS - 1);
      r_fault    <= 1'b0;
      r_busy     <= 1'b0;
      r_hold_cnt <= '0;
      r_cd_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_bludged  <= w_bludged_nxt;
      r_target   <= w_target_nxt;
      r_fault    <= w_fault_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_hold_cnt <= w_hold_nxt;
      r_cd_cnt   <= w_cd_nxt;
    end
  end

  assign bludged = r_bludged;
  assign target  = r_target;
  assign busy    = r_busy;
  assign fault   = r_fault;

endmodule

// File: tb/tb_bludger_scheduler.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares each cycle.
module tb_bludger_scheduler;

  localparam int NP = 4;
  localparam int CD = 8;
  localparam int MH = 20;
  localparam int M_IDLE = 0;
  localparam int M_HIT  = 1;
  localparam int M_COOL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_active = 1'b0;
  logic [3:0] hit_req = '0;
  logic [3:0] clean_bludge = '0;
  logic [3:0] bludged;
  logic [1:0] target;
  logic       busy;
  logic       fault;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] bl;
    logic [1:0] tg;
    logic       bs;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];

  // Reference: who holds the bludger, how long it has been held, how long we have rested.
  int m_mode, m_target, m_fault, m_held, m_rested;

  always #5 clk = ~clk;

  bludger_scheduler #(
    .N_PLAYERS       (NP),
    .COOLDOWN_CYCLES (CD),
    .MAX_HOLD_CYCLES (MH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .game_active  (game_active),
    .hit_req      (hit_req),
    .clean_bludge (clean_bludge),
    .bludged      (bludged),
    .target       (target),
    .busy         (busy),
    .fault        (fault)
  );

  task automatic model_reset();
    m_mode = M_IDLE; m_target = NP - 1; m_fault = 0; m_held = 0; m_rested = 0;
  endtask

  task automatic model_edge(input bit ga, input logic [3:0] rq, input logic [3:0] cl);
    int c;
    if (!ga) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (rq != 4'b0) begin
        for (int k = 1; k <= NP; k++) begin
          c = (m_target + k) % NP;
          if (((rq >> c) & 4'd1) != 4'd0) begin
            m_target = c;
            break;
          end
        end
        m_mode = M_HIT;
        m_held = 0;
      end
    end else if (m_mode == M_HIT) begin
      m_held++;
      if (((cl >> m_target) & 4'd1) != 4'd0) begin
        m_mode = M_COOL; m_rested = 0;
      end else if (m_held == MH) begin
        m_fault = 1; m_mode = M_COOL; m_rested = 0;
      end
    end else begin
      m_rested++;
      if (m_rested == CD) m_mode = M_IDLE;
    end
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.bl = (m_mode == M_HIT) ? 4'(1 << m_target) : 4'b0;
    e.tg = 2'(m_target);
    e.bs = (m_mode != M_IDLE);
    e.ft = (m_fault != 0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit ga, input logic [3:0] rq, input logic [3:0] cl);
    game_active = ga; hit_req = rq; clean_bludge = cl;
    model_edge(ga, rq, cl);
    exp_q.push_back(model_view());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_bludged", 32'(bludged), 32'h0);
    chk("rst_target",  32'(target),  32'h3);
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_fault",   32'(fault),   32'h0);
    model_reset();
    game_active = 1'b0; hit_req = '0; clean_bludge = '0;
    exp_q.push_back(model_view());
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bludged, target, busy, fault} !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: bludged=%b target=%0d busy=%b fault=%b required bludged=%b target=%0d busy=%b fault=%b",
                   $time, bludged, target, busy, fault, e.bl, e.tg, e.bs, e.ft);
        end
      end
    end
  end

  initial begin : timeout
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit ga;
    logic [3:0] rq, cl;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_bludged", 32'(bludged), 32'h0);
    chk("init_target",  32'(target),  32'h3);
    chk("init_busy",    32'(busy),    32'h0);
    chk("init_fault",   32'(fault),   32'h0);
    rst_n = 1'b1;

    // First grant prefers player 0
    step(1, 4'b0101, 4'b0000);
    chk("s1_bludged", 32'(bludged), 32'h1);
    chk("s1_target",  32'(target),  32'h0);
    chk("s1_busy",    32'(busy),    32'h1);

    // Non-target clean is ignored
    repeat (3) step(1, 4'b0101, 4'b0010);
    chk("s6_bludged", 32'(bludged), 32'h1);

    // Clean release then exactly CD busy cycles, then rotate to player 2
    step(1, 4'b0101, 4'b0001);
    chk("s2_release", 32'(bludged), 32'h0);
    chk("s2_busy",    32'(busy),    32'h1);
    repeat (7) step(1, 4'b0101, 4'b0000);
    chk("s2_cool_last", 32'(busy), 32'h1);
    step(1, 4'b0101, 4'b0000);
    chk("s2_cool_done", 32'(busy), 32'h0);
    step(1, 4'b0101, 4'b0000);
    chk("s2_target",  32'(target),  32'h2);
    chk("s2_bludged", 32'(bludged), 32'h4);

    // Watchdog expiry after MH cycles of holding
    repeat (19) step(1, 4'b0000, 4'b0000);
    chk("s3_hold", 32'(bludged), 32'h4);
    step(1, 4'b0000, 4'b0000);
    chk("s3_drop",  32'(bludged), 32'h0);
    chk("s3_fault", 32'(fault),   32'h1);
    chk("s3_busy",  32'(busy),    32'h1);
    repeat (8) step(1, 4'b0000, 4'b0000);
    chk("s3_idle", 32'(busy), 32'h0);

    // Abort mid-HIT
    step(1, 4'b1000, 4'b0000);
    chk("s4_target", 32'(target), 32'h3);
    step(1, 4'b1000, 4'b0000);
    step(0, 4'b1000, 4'b0000);
    chk("s4_bludged", 32'(bludged), 32'h0);
    chk("s4_busy",    32'(busy),    32'h0);
    chk("s4_target",  32'(target),  32'h3);
    chk("s4_fault",   32'(fault),   32'h1);

    // Reset mid-COOLDOWN
    step(1, 4'b0010, 4'b0000);
    step(1, 4'b0000, 4'b0010);
    step(1, 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b0000);
    async_reset();

    // Clean release on the watchdog's last cycle wins, no fault
    step(1, 4'b0001, 4'b0000);
    repeat (19) step(1, 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b0001);
    chk("tie_bludged", 32'(bludged), 32'h0);
    chk("tie_fault",   32'(fault),   32'h0);
    chk("tie_busy",    32'(busy),    32'h1);

    for (int i = 0; i < 800; i++) begin
      ga = ($urandom_range(0, 24) != 0);
      rq = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom);
      cl = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 249) == 0) async_reset();
      else step(ga, rq, cl);
    end

    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bludger_scheduler.md
BLUDGER_SCHEDULER -- requirements
Module: bludger_scheduler

Interface
REQ-001 Parameter N_PLAYERS, default 4: number of player controllers sharing the single bludger.
REQ-002 Parameter COOLDOWN_CYCLES, default 100000000: idle clocks enforced after each release before the next grant.
REQ-003 Parameter MAX_HOLD_CYCLES, default 600000000: watchdog limit on one hit.
REQ-004 Port clk, input, 1 bit: system clock; all logic SHALL be rising-edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port game_active, input, 1 bit: 1 = match running; 0 = abort and hold idle.
REQ-007 Port hit_req, input, N_PLAYERS bits: per-player collision request, level-sensitive.
REQ-008 Port clean_bludge, input, N_PLAYERS bits: per-player recovery-complete flag from that player's controller.
REQ-009 Port bludged, output, N_PLAYERS bits: one-hot hit indication to player controllers.
REQ-010 Port target, output, clog2(N_PLAYERS) bits: index of the current or last granted player.
REQ-011 Port busy, output, 1 bit: 1 in HIT or COOLDOWN.
REQ-012 Port fault, output, 1 bit: sticky watchdog-expiry flag.

Function
REQ-013 FSM states: IDLE, HIT, COOLDOWN.
REQ-014 IDLE -> HIT when game_active=1 and hit_req!=0; grant is chosen round-robin, starting at (last target+1) mod N_PLAYERS.
REQ-015 Grant latency: bludged[grant] rises on the clock edge that samples the request, i.e. 1 cycle after hit_req is stable.
REQ-016 bludged SHALL be one-hot or zero; it SHALL be nonzero only in HIT.
REQ-017 In HIT, hit_req is ignored; further requests are neither queued nor latched.
REQ-018 HIT -> COOLDOWN when clean_bludge[target]=1; bludged clears on that same edge.
REQ-019 clean_bludge bits of non-target players are ignored.
REQ-020 HIT watchdog: a counter runs from 0 in HIT.
  - if it reaches MAX_HOLD_CYCLES-1 without clean_bludge[target], go to COOLDOWN, clear bludged, set fault=1.
REQ-021 COOLDOWN counter loads COOLDOWN_CYCLES-1 on entry and decrements each cycle.
  - at 0, go to IDLE; COOLDOWN lasts exactly COOLDOWN_CYCLES cycles.
REQ-022 If game_active=0 in any state: go to IDLE next edge, clear bludged, clear counters; target and fault are retained.
REQ-023 Simultaneous clean_bludge[target] and watchdog expiry: clean release wins and fault stays unchanged.
REQ-024 Simultaneous game_active fall and any other event: abort wins.
REQ-025 Counter widths SHALL be clog2 of the larger of COOLDOWN_CYCLES and MAX_HOLD_CYCLES; counters SHALL never wrap.
REQ-026 fault clears only on reset.

Reset
REQ-027 When rst_n=0: state=IDLE, bludged=0, target=N_PLAYERS-1 (first grant prefers player 0), busy=0, fault=0, counters=0.
REQ-028 Reset takes effect immediately, including mid-HIT or mid-COOLDOWN; release is synchronized so the first active edge after deassertion sees IDLE.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE/HIT/COOLDOWN) and the default N_PLAYERS constant.
REQ-030 Round-robin selection SHALL live in one sub-module, rr_arbiter (inputs req and last grant; outputs one-hot grant and index).
  - it SHALL be combinational; its pointer register stays in bludger_scheduler.

Verification
REQ-031 Bench SHALL use N_PLAYERS=4, COOLDOWN_CYCLES=8, MAX_HOLD_CYCLES=20.
  - Scenario 1: after reset, hit_req=4'b0101 -> next cycle bludged=4'b0001, target=0, busy=1.
  - Scenario 2: clean_bludge[0] pulses -> bludged=0 same edge, busy=1 for 8 cycles; hit_req held 4'b0101 then grants target=2.
  - Scenario 3: target=2, clean_bludge held 0 -> bludged drops after 20 cycles, fault=1, COOLDOWN entered.
  - Scenario 4: game_active=0 mid-HIT -> bludged=0 and busy=0 next cycle; target unchanged.
  - Scenario 5: rst_n=0 mid-COOLDOWN -> all outputs at reset values immediately, fault=0, target=3.
  - Scenario 6: clean_bludge[1] asserted while target=0 -> no state change.
